dsp_mac_array: RTL and testbench
================================

# dsp_mac_array

Parametrised, pipelined multi-lane multiply-accumulate engine for CNN convolution kernels. It is the multi-cycle successor to the single multiply-add DSP primitive. Each lane takes a stream of signed operand pairs framed by first/last markers, adds a per-lane bias, and accumulates the products. On the last beat it emits one shifted, saturated result per lane. It sits between the window/weight fetch logic and the activation/requantisation stage.

## Interface
- `DATA_W`, 8: signed operand width.
- `LANES`, 4: number of parallel MAC lanes (output channels).
- `ACC_W`, 24: signed accumulator and bias width. Must be ≥ 2*`DATA_W`.
- `OUT_W`, 8: signed result width after requantisation.
- `SHIFT`, 0: arithmetic right shift applied to the accumulator before saturation. Range 0..`ACC_W`-`OUT_W`.

- `clock`  in  1  sole clock, rising edge.
- `aclr_n`  in  1  asynchronous, active-low reset.
- `clken`  in  1  global enable. When low, every register holds its value.
- `in_valid`  in  1  input beat present.
- `in_first`  in  1  beat opens a new accumulation and loads `sumin`.
- `in_last`  in  1  beat closes the accumulation and a result is produced.
- `dataa`  in  `LANES`*`DATA_W`  signed operand A. Lane i is at bits [i*`DATA_W` +: `DATA_W`].
- `datab`  in  `LANES`*`DATA_W`  signed operand B, same packing as `dataa`.
- `sumin`  in  `LANES`*`ACC_W`  signed per-lane bias. Sampled only on a first beat.
- `out_valid`  out  1  result present.
- `result`  out  `LANES`*`OUT_W`  signed saturated results.
- `out_sat`  out  `LANES`  per-lane flag: the result was clipped.
- `err_restart`  out  1  pulse: `in_first` arrived while an accumulation was still open.

## Operation
- **Accepted beat:** `in_valid`=1 and `clken`=1 at a rising edge. No backpressure exists; upstream stalls the block only through `clken`.
- **Pipeline stages:**
  - S1 registers the operands and the marker bits.
  - S2 registers the full-precision product `a*b` (2*`DATA_W` bits), sign-extended to `ACC_W`.
  - S3 is the accumulator.
  - S4 is the output register.
- **Control FSM** (shared by all lanes, advances at S3):
  - IDLE:
    - first beat → acc = `sumin` + product, go to ACCUM.
    - non-first beat → acc = 0 + product (bias ignored), go to ACCUM.
  - ACCUM:
    - non-first beat → acc += product.
    - first beat → acc = `sumin` + product (partial sum discarded), pulse `err_restart`, stay in ACCUM.
  - A beat carrying `in_last` → the S3 value including that beat goes to S4, and the FSM returns to IDLE.
  - `in_first` and `in_last` on the same beat → single-term result `sumin` + a*b.
- **Arithmetic:**
  - Accumulator wraps as `ACC_W` two's complement.
  - Output = acc >>> `SHIFT` (arithmetic shift, floor), then clamped to [-2^(`OUT_W`-1), 2^(`OUT_W`-1)-1].
  - `out_sat`[i] = 1 exactly when lane i was clamped.

## Timing
- **Reset values:** `aclr_n` low asynchronously clears all stage registers and the accumulator; FSM goes to IDLE. `out_valid`=0, `result`=0, `out_sat`=0, `err_restart`=0.
- **Latency:** a last beat accepted at enabled edge k gives `out_valid`=1 after enabled edge k+3, i.e. 4 enabled edges counting the acceptance edge.
- **Throughput:** one beat per enabled cycle. Back-to-back sequences are allowed: a first beat may directly follow a last beat with no bubble.
- **`out_valid` and `err_restart`:** each is high for exactly one enabled cycle. While `clken`=0 they hold their value, so consumers qualify them with `clken`.
- **`in_valid`=0 cycles:** bubbles move through the pipeline and do not alter the accumulator.
- **Reset mid-sequence:** the partial sum is lost and no `out_valid` is produced for that sequence. The first accepted beat after release is handled from IDLE.

## Structure
- Package `dsp_pkg`:
  - FSM state enum {IDLE, ACCUM}.
  - Pipeline latency constant = 4.
  - A saturate/shift function, parametrised by the widths.
- Sub-module `dsp_mac_lane`: one lane's S1–S4 datapath (product, accumulator, shift/saturate). It is instantiated `LANES` times by a generate loop.
- The top level holds the FSM, the marker/valid shift registers and `err_restart`.

## Test plan
Configuration: `LANES`=2, `DATA_W`=8, `ACC_W`=24, `OUT_W`=8, `SHIFT`=0, `clken`=1 unless stated.
1. **Single term:** lane0 a=1, b=2, `sumin`=3, first+last → 4 edges later `result`[0]=5, `out_valid` high for 1 cycle, `out_sat`=0.
2. **Dot product:** three beats on lane0, (1,2) first with bias 0, then (3,4), then (-5,6) last → `result`[0]=-16. Lane1 (2,2)×3 beats with bias 1 → 13.
3. **Saturation:** first+last with 127*127 → 127, `out_sat`[0]=1. With -128*127 → -128, `out_sat`=1. Repeat with `SHIFT`=7: 127*127>>>7 = 126, no saturation.
4. **Stall:** drop `clken` for 5 cycles between beats 2 and 3 of scenario 2 → same -16, `out_valid` delayed by exactly 5 cycles.
5. **Reset mid-sequence:** assert `aclr_n`=0 after beat 2 → outputs 0 immediately, no `out_valid`. A fresh single-term sequence then returns 5 as in scenario 1.
6. **Restart:** first (1,1), then first+last (2,3) with bias 0 → `err_restart` pulses 1 cycle, `result`[0]=6 (old term discarded). A back-to-back last→first pair produces two `out_valid` pulses one cycle apart.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared types, constants and requantisation helpers for the MAC array.
package dsp_pkg;

  // Accumulation control state shared by every lane.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } mac_state_e;

  // Enabled edges from accepting a last beat to the result being visible.
  localparam int unsigned PIPE_LAT = 32'd4;

  // Working width of the requantisation helpers; callers sign-extend into it.
  localparam int unsigned SAT_W = 32'd64;

  // Arithmetic right shift (floor) followed by a clamp to a signed out_w range.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int unsigned             out_w,
    input int unsigned             shift
  );
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    shifted = acc >>> shift;
    max_v   = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (out_w - 32'd1));
    if (shifted > max_v) begin
      sat_shift = max_v;
    end else if (shifted < min_v) begin
      sat_shift = min_v;
    end else begin
      sat_shift = shifted;
    end
  endfunction

  // True when sat_shift would have to clip the shifted value.
  function automatic logic sat_hit(
    input logic signed [SAT_W-1:0] acc,
    input int unsigned             out_w,
    input int unsigned             shift
  );
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    shifted = acc >>> shift;
    max_v   = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (out_w - 32'd1));
    sat_hit = (shifted > max_v) || (shifted < min_v);
  endfunction

endpackage

// File: rtl/dsp_mac_lane.sv
// One MAC lane: operand register, product register, accumulator and
// shifted/saturated output register. Sequencing comes from the top level.
module dsp_mac_lane
  import dsp_pkg::*;
#(
  parameter int unsigned DATA_W = 32'd8,
  parameter int unsigned ACC_W  = 32'd24,
  parameter int unsigned OUT_W  = 32'd8,
  parameter int unsigned SHIFT  = 32'd0
) (
  input  logic                     clock,
  input  logic                     aclr_n,
  input  logic                     clken,
  input  logic                     s1_load,
  input  logic                     bias_load,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  input  logic signed [ACC_W-1:0]  bias_in,
  input  logic                     acc_en,
  input  logic                     acc_restart,
  input  logic                     bias_sel,
  input  logic                     out_load,
  output logic signed [OUT_W-1:0]  result,
  output logic                     out_sat
);

  logic signed [DATA_W-1:0]   a1_q, a1_d;
  logic signed [DATA_W-1:0]   b1_q, b1_d;
  logic signed [ACC_W-1:0]    bias1_q, bias1_d;
  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]    prod2_q, prod2_d;
  logic signed [ACC_W-1:0]    bias2_q, bias2_d;
  logic signed [ACC_W-1:0]    base_s;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [SAT_W-1:0]    acc_ext_s;
  logic signed [OUT_W-1:0]    res_q, res_d;
  logic                       sat_q, sat_d;

  // S1: capture operands on a valid beat; the bias only on a first beat.
  always_comb begin
    a1_d    = a1_q;
    b1_d    = b1_q;
    bias1_d = bias1_q;
    if (s1_load) begin
      a1_d = a_in;
      b1_d = b_in;
    end else begin
      a1_d = a1_q;
      b1_d = b1_q;
    end
    if (bias_load) begin
      bias1_d = bias_in;
    end else begin
      bias1_d = bias1_q;
    end
  end

  // S2: full-precision signed product, sign-extended to the accumulator width.
  always_comb begin
    prod_s  = (2*DATA_W)'(a1_q) * (2*DATA_W)'(b1_q);
    prod2_d = ACC_W'(prod_s);
    bias2_d = bias1_q;
  end

  // S3: restart from bias or zero, or keep summing; wraps at ACC_W bits.
  always_comb begin
    base_s = acc_q;
    acc_d  = acc_q;
    if (bias_sel) begin
      base_s = bias2_q;
    end else if (acc_restart) begin
      base_s = '0;
    end else begin
      base_s = acc_q;
    end
    if (acc_en) begin
      acc_d = base_s + prod2_q;
    end else begin
      acc_d = acc_q;
    end
  end

  // S4: requantise the closed accumulation; hold the last result otherwise.
  always_comb begin
    acc_ext_s = SAT_W'(acc_q);
    res_d     = res_q;
    sat_d     = sat_q;
    if (out_load) begin
      res_d = OUT_W'(sat_shift(acc_ext_s, OUT_W, SHIFT));
      sat_d = sat_hit(acc_ext_s, OUT_W, SHIFT);
    end else begin
      res_d = res_q;
      sat_d = sat_q;
    end
  end

  // Lane registers: async clear, frozen while clken is low.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      a1_q    <= '0;
      b1_q    <= '0;
      bias1_q <= '0;
      prod2_q <= '0;
      bias2_q <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
    end else if (clken) begin
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      bias1_q <= bias1_d;
      prod2_q <= prod2_d;
      bias2_q <= bias2_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
    end
  end

  assign result  = res_q;
  assign out_sat = sat_q;

endmodule

// File: rtl/dsp_mac_array.sv
// Multi-lane pipelined MAC engine. Holds the shared accumulation FSM, the
// valid/marker pipeline and the restart error pulse; lanes do the arithmetic.
// ACC_W must be at least 2*DATA_W and SHIFT at most ACC_W-OUT_W.
module dsp_mac_array
  import dsp_pkg::*;
#(
  parameter int unsigned DATA_W = 32'd8,
  parameter int unsigned LANES  = 32'd4,
  parameter int unsigned ACC_W  = 32'd24,
  parameter int unsigned OUT_W  = 32'd8,
  parameter int unsigned SHIFT  = 32'd0
) (
  input  logic                    clock,
  input  logic                    aclr_n,
  input  logic                    clken,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [LANES*DATA_W-1:0] dataa,
  input  logic [LANES*DATA_W-1:0] datab,
  input  logic [LANES*ACC_W-1:0]  sumin,
  output logic                    out_valid,
  output logic [LANES*OUT_W-1:0]  result,
  output logic [LANES-1:0]        out_sat,
  output logic                    err_restart
);

  mac_state_e state_q, state_d;
  logic v1_q, v1_d, f1_q, f1_d, l1_q, l1_d;
  logic v2_q, v2_d, f2_q, f2_d, l2_q, l2_d;
  logic last3_q, last3_d;
  logic out_valid_q, out_valid_d;
  logic err_q, err_d;
  logic acc_restart_s;

  // Marker pipeline: markers are qualified by in_valid so bubbles carry none.
  always_comb begin
    v1_d        = in_valid;
    f1_d        = in_valid & in_first;
    l1_d        = in_valid & in_last;
    v2_d        = v1_q;
    f2_d        = f1_q;
    l2_d        = l1_q;
    last3_d     = v2_q & l2_q;
    out_valid_d = last3_q;
  end

  // FSM decode at S3: choose the accumulator base and flag a restart.
  always_comb begin
    state_d       = state_q;
    err_d         = 1'b0;
    acc_restart_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (v2_q) begin
          acc_restart_s = 1'b1;
          state_d       = l2_q ? IDLE : ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (v2_q) begin
          acc_restart_s = f2_q;
          err_d         = f2_q;
          state_d       = l2_q ? IDLE : ACCUM;
        end else begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers: FSM state, marker pipeline and registered pulses.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q     <= IDLE;
      v1_q        <= 1'b0;
      f1_q        <= 1'b0;
      l1_q        <= 1'b0;
      v2_q        <= 1'b0;
      f2_q        <= 1'b0;
      l2_q        <= 1'b0;
      last3_q     <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (clken) begin
      state_q     <= state_d;
      v1_q        <= v1_d;
      f1_q        <= f1_d;
      l1_q        <= l1_d;
      v2_q        <= v2_d;
      f2_q        <= f2_d;
      l2_q        <= l2_d;
      last3_q     <= last3_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dsp_mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W),
      .SHIFT  (SHIFT)
    ) u_lane (
      .clock       (clock),
      .aclr_n      (aclr_n),
      .clken       (clken),
      .s1_load     (in_valid),
      .bias_load   (in_valid & in_first),
      .a_in        (dataa[i*DATA_W +: DATA_W]),
      .b_in        (datab[i*DATA_W +: DATA_W]),
      .bias_in     (sumin[i*ACC_W +: ACC_W]),
      .acc_en      (v2_q),
      .acc_restart (acc_restart_s),
      .bias_sel    (f2_q),
      .out_load    (last3_q),
      .result      (result[i*OUT_W +: OUT_W]),
      .out_sat     (out_sat[i])
    );
  end

  assign out_valid   = out_valid_q;
  assign err_restart = err_q;

endmodule

// File: tb/tb_dsp_mac_array.sv
// Bench for dsp_mac_array: two instances (SHIFT=0 and SHIFT=7) on the same
// stimulus, checked every cycle against a beat-level accumulation model,
// plus hand-computed expectations for the directed scenarios.
module tb_dsp_mac_array;

  localparam int DW = 8;
  localparam int LN = 2;
  localparam int AW = 24;
  localparam int OW = 8;
  localparam int PERIOD = 10;
  localparam int DEPTH = 1024;

  logic clock = 1'b0;
  logic aclr_n;
  logic clken;
  logic in_valid, in_first, in_last;
  logic [LN*DW-1:0] dataa, datab;
  logic [LN*AW-1:0] sumin;
  logic out_valid, err_restart, out_valid7, err_restart7;
  logic [LN*OW-1:0] result, result7;
  logic [LN-1:0] out_sat, out_sat7;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  time t_start = 0;

  always #(PERIOD/2) clock = ~clock;

  dsp_mac_array #(.DATA_W(DW), .LANES(LN), .ACC_W(AW), .OUT_W(OW), .SHIFT(0)) u_dut (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .dataa(dataa), .datab(datab),
    .sumin(sumin), .out_valid(out_valid), .result(result), .out_sat(out_sat),
    .err_restart(err_restart));

  dsp_mac_array #(.DATA_W(DW), .LANES(LN), .ACC_W(AW), .OUT_W(OW), .SHIFT(7)) u_dut7 (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .dataa(dataa), .datab(datab),
    .sumin(sumin), .out_valid(out_valid7), .result(result7), .out_sat(out_sat7),
    .err_restart(err_restart7));

  // ---------------- behavioural model ----------------
  int     edge_n = 0;
  bit     open_seq = 1'b0;
  longint macc [LN];
  bit     exp_valid [DEPTH];
  bit     exp_err   [DEPTH];
  int     exp_r0 [DEPTH][LN];
  int     exp_r7 [DEPTH][LN];
  bit     exp_s0 [DEPTH][LN];
  bit     exp_s7 [DEPTH][LN];

  function automatic longint wrap_acc(input longint x);
    longint w;
    w = x & 64'sh0000_0000_00FF_FFFF;
    if (w >= 64'sd8388608) w = w - 64'sd16777216;
    return w;
  endfunction

  function automatic void clip(input longint acc, input int sh, output int v, output bit s);
    longint t;
    t = acc >>> sh;
    s = 1'b0;
    if (t > 64'sd127) begin v = 127; s = 1'b1; end
    else if (t < -64'sd128) begin v = -128; s = 1'b1; end
    else v = int'(t);
  endfunction

  // Model: every accepted beat updates the per-lane sums; a last beat
  // schedules the result three enabled edges later, a restart flags err two later.
  always @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      open_seq = 1'b0;
      for (int i = 0; i < 5; i++) begin
        exp_valid[edge_n + i] = 1'b0;
        exp_err[edge_n + i] = 1'b0;
      end
    end else if (clken) begin
      edge_n = edge_n + 1;
      if (in_valid) begin
        if (in_first && open_seq) exp_err[edge_n + 2] = 1'b1;
        for (int l = 0; l < LN; l++) begin
          longint av, bv, sv;
          av = longint'($signed(dataa[l*DW +: DW]));
          bv = longint'($signed(datab[l*DW +: DW]));
          sv = longint'($signed(sumin[l*AW +: AW]));
          if (in_first) macc[l] = wrap_acc(sv + av * bv);
          else if (open_seq) macc[l] = wrap_acc(macc[l] + av * bv);
          else macc[l] = wrap_acc(av * bv);
        end
        open_seq = 1'b1;
        if (in_last) begin
          open_seq = 1'b0;
          exp_valid[edge_n + 3] = 1'b1;
          for (int l = 0; l < LN; l++) begin
            clip(macc[l], 0, exp_r0[edge_n + 3][l], exp_s0[edge_n + 3][l]);
            clip(macc[l], 7, exp_r7[edge_n + 3][l], exp_s7[edge_n + 3][l]);
          end
        end
      end
    end
  end

  // Compare process: every cycle out of reset, both instances against the model.
  always @(negedge clock) begin
    if (aclr_n && chk_en) begin
      int n;
      n = edge_n;
      tests++;
      if (out_valid !== exp_valid[n] || out_valid7 !== exp_valid[n]) begin
        fails++;
        $display("FAIL model_out_valid edge %0d: got %b/%b required %b", n, out_valid, out_valid7, exp_valid[n]);
      end
      tests++;
      if (err_restart !== exp_err[n] || err_restart7 !== exp_err[n]) begin
        fails++;
        $display("FAIL model_err_restart edge %0d: got %b/%b required %b", n, err_restart, err_restart7, exp_err[n]);
      end
      if (exp_valid[n]) begin
        for (int l = 0; l < LN; l++) begin
          tests++;
          if (int'($signed(result[l*OW +: OW])) != exp_r0[n][l] || out_sat[l] !== exp_s0[n][l]) begin
            fails++;
            $display("FAIL model_result_sh0 lane %0d: got %0d sat %b required %0d sat %b", l,
                     $signed(result[l*OW +: OW]), out_sat[l], exp_r0[n][l], exp_s0[n][l]);
          end
          tests++;
          if (int'($signed(result7[l*OW +: OW])) != exp_r7[n][l] || out_sat7[l] !== exp_s7[n][l]) begin
            fails++;
            $display("FAIL model_result_sh7 lane %0d: got %0d sat %b required %0d sat %b", l,
                     $signed(result7[l*OW +: OW]), out_sat7[l], exp_r7[n][l], exp_s7[n][l]);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic f, input logic l,
                       input int a0, input int b0, input int a1, input int b1,
                       input int s0, input int s1);
    @(negedge clock);
    clken    = 1'b1;
    in_valid = v;
    in_first = f;
    in_last  = l;
    dataa    = {8'(a1), 8'(a0)};
    datab    = {8'(b1), 8'(b0)};
    sumin    = {24'(s1), 24'(s0)};
    if (v && f) t_start = $time;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  // Idles until out_valid (bounded), then checks lane results, lane0 sat,
  // the SHIFT=7 lane0 result and the delay since the first beat in periods.
  task automatic wait_out(input string name, input int e0, input int e1,
                          input int es0, input int e7, input int dly);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idle();
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_timeout: got no out_valid required out_valid=1 within 16 cycles", name);
    end else begin
      check({name, "_lane0"}, int'($signed(result[7:0])), e0);
      check({name, "_lane1"}, int'($signed(result[15:8])), e1);
      check({name, "_sat0"}, int'(out_sat[0]), es0);
      check({name, "_shift7_lane0"}, int'($signed(result7[7:0])), e7);
      check({name, "_delay"}, int'(($time - t_start) / PERIOD), dly);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int errs, valids, res, vcyc0, vcyc1, r0, r1;
    clken = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    dataa = '0; datab = '0; sumin = '0;
    aclr_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_result", int'(result), 0);
    check("reset_out_sat", int'(out_sat), 0);
    check("reset_err_restart", int'(err_restart), 0);
    aclr_n = 1'b1;
    chk_en = 1'b1;
    idle();

    // single term: 3 + 1*2
    drive(1'b1, 1'b1, 1'b1, 1, 2, 0, 0, 3, 0);
    wait_out("single", 5, 0, 0, 0, 4);

    // dot product: lane0 2+12-30, lane1 1+4+4+4
    drive(1'b1, 1'b1, 1'b0, 1, 2, 2, 2, 0, 1);
    drive(1'b1, 1'b0, 1'b0, 3, 4, 2, 2, 0, 0);
    drive(1'b1, 1'b0, 1'b1, -5, 6, 2, 2, 0, 0);
    wait_out("dot", -16, 13, 0, -1, 6);

    // saturation: 16129 -> 127 (>>>7: 126), -16256 -> -128 (>>>7: -127)
    drive(1'b1, 1'b1, 1'b1, 127, 127, 0, 0, 0, 0);
    wait_out("sat_pos", 127, 0, 1, 126, 4);
    drive(1'b1, 1'b1, 1'b1, -128, 127, 0, 0, 0, 0);
    wait_out("sat_neg", -128, 0, 1, -127, 4);

    // stall: five disabled cycles (with junk on the bus) before beat 3
    drive(1'b1, 1'b1, 1'b0, 1, 2, 2, 2, 0, 1);
    drive(1'b1, 1'b0, 1'b0, 3, 4, 2, 2, 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      clken = 1'b0; in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
      dataa = 16'h0909; datab = 16'h0909;
    end
    drive(1'b1, 1'b0, 1'b1, -5, 6, 2, 2, 0, 0);
    wait_out("stall", -16, 13, 0, -1, 11);

    // reset mid-sequence: outputs clear at once, nothing emerges afterwards
    drive(1'b1, 1'b1, 1'b0, 1, 2, 2, 2, 0, 1);
    drive(1'b1, 1'b0, 1'b0, 3, 4, 2, 2, 0, 0);
    @(negedge clock);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    aclr_n = 1'b0;
    #1;
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_result", int'(result), 0);
    check("midreset_out_sat", int'(out_sat), 0);
    repeat (2) @(negedge clock);
    aclr_n = 1'b1;
    valids = 0;
    for (int k = 0; k < 8; k++) begin
      idle();
      if (out_valid) valids++;
    end
    check("midreset_no_valid", valids, 0);
    // non-first last beat from IDLE: bias ignored, sum restarts from 0 -> 6
    drive(1'b1, 1'b0, 1'b1, 2, 3, 0, 0, 100, 0);
    t_start = $time;
    wait_out("idle_nonfirst", 6, 0, 0, 0, 4);
    drive(1'b1, 1'b1, 1'b1, 1, 2, 0, 0, 3, 0);
    wait_out("after_reset", 5, 0, 0, 0, 4);

    // restart: open with (1,1), reopen with first+last (2,3) -> 6, one err pulse
    drive(1'b1, 1'b1, 1'b0, 1, 1, 0, 0, 0, 0);
    drive(1'b1, 1'b1, 1'b1, 2, 3, 0, 0, 0, 0);
    errs = 0; valids = 0; res = 0;
    for (int k = 0; k < 8; k++) begin
      idle();
      if (err_restart) errs++;
      if (out_valid) begin valids++; res = int'($signed(result[7:0])); end
    end
    check("restart_err_pulses", errs, 1);
    check("restart_valid_pulses", valids, 1);
    check("restart_result", res, 6);

    // back-to-back single terms: 3+1*2 then 0+2*2, valid on adjacent cycles
    drive(1'b1, 1'b1, 1'b1, 1, 2, 0, 0, 3, 0);
    drive(1'b1, 1'b1, 1'b1, 2, 2, 0, 0, 0, 0);
    valids = 0; vcyc0 = -1; vcyc1 = -1; r0 = 0; r1 = 0;
    for (int k = 0; k < 8; k++) begin
      idle();
      if (out_valid) begin
        if (valids == 0) begin vcyc0 = k; r0 = int'($signed(result[7:0])); end
        else begin vcyc1 = k; r1 = int'($signed(result[7:0])); end
        valids++;
      end
    end
    check("b2b_valid_pulses", valids, 2);
    check("b2b_gap", vcyc1 - vcyc0, 1);
    check("b2b_first_result", r0, 5);
    check("b2b_second_result", r1, 4);

    repeat (4) idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
